// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-N up/down counter.
//  cnt_mode_t    : terminal-count behaviour selector (RSVD behaves as WRAP)
//  params_legal  : elaboration-time parameter sanity check
package counter_pkg;

    typedef enum logic [1:0] {
        WRAP    = 2'b00,
        SAT     = 2'b01,
        ONESHOT = 2'b10,
        RSVD    = 2'b11
    } cnt_mode_t;

    // True when the width/modulus/prescale combination is usable.
    function automatic bit params_legal(input int width, input int modulus, input int prescale);
        return (width >= 32'sd1) && (width <= 32'sd30) &&
               (modulus >= 32'sd2) && (modulus <= (32'sd1 << width)) &&
               (prescale >= 32'sd1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable prescaler: emits tick on every PRESCALE-th enabled cycle.
//  clk  : rising-edge clock
//  rst  : synchronous active-high reset
//  en   : count enable; when low the phase is held
//  clr  : synchronous restart of the phase (discards a partial count)
//  tick : high on the enabled cycle that completes a prescale period
// With PRESCALE=1 the phase register is constantly 0, so tick equals en.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_r;

    // Phase counter over enabled cycles, wrapping at the end of each period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r <= '0;
        end else if (clr) begin
            pre_r <= '0;
        end else if (en) begin
            pre_r <= (pre_r == LAST) ? '0 : pre_r + PW'(1'b1);
        end else begin
            pre_r <= pre_r;
        end
    end

    assign tick = en & (pre_r == LAST);

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised modulo-MODULUS up/down counter with prescaler and
// wrap / saturate / one-shot terminal behaviour.
//  clk, rst  : clock and synchronous active-high reset
//  en, up    : count enable and direction (1 = up)
//  mode      : 00 WRAP, 01 SAT, 10 ONESHOT, 11 as WRAP
//  clr       : synchronous clear of count and flags
//  load      : synchronous load of load_val, clamped to MODULUS-1
//  cnt       : registered count
//  tc        : one-cycle pulse after a step taken at the boundary
//  ovf       : sticky boundary-hit flag
//  done      : one-shot finished, counter frozen until clr/load/rst
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf,
    output logic             done
);

    if (!params_legal(WIDTH, MODULUS, PRESCALE)) begin : g_bad_params
        $error("updown_counter_mod: illegal WIDTH/MODULUS/PRESCALE");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] cnt_r, cnt_nxt_s;
    logic             tc_r, tc_nxt_s;
    logic             ovf_r, ovf_nxt_s;
    logic             done_r, done_nxt_s;
    logic             tick_s, step_s, at_b_s;

    // Loading also restarts the prescale phase.
    tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr | load),
        .tick (tick_s)
    );

    assign step_s = tick_s & ~done_r;
    assign at_b_s = up ? (cnt_r == MAX) : (cnt_r == '0);

    // Next-state selection: clr > load > step (rst handled in the register).
    always_comb begin
        cnt_nxt_s  = cnt_r;
        tc_nxt_s   = 1'b0;
        ovf_nxt_s  = ovf_r;
        done_nxt_s = done_r;
        if (clr) begin
            cnt_nxt_s  = '0;
            ovf_nxt_s  = 1'b0;
            done_nxt_s = 1'b0;
        end else if (load) begin
            cnt_nxt_s  = (load_val > MAX) ? MAX : load_val;
            done_nxt_s = 1'b0;
        end else if (step_s) begin
            if (!at_b_s) begin
                cnt_nxt_s = up ? cnt_r + WIDTH'(1'b1) : cnt_r - WIDTH'(1'b1);
            end else begin
                tc_nxt_s  = 1'b1;
                ovf_nxt_s = 1'b1;
                case (cnt_mode_t'(mode))
                    WRAP, RSVD: cnt_nxt_s  = up ? '0 : MAX;
                    SAT:        cnt_nxt_s  = cnt_r;
                    ONESHOT:    done_nxt_s = 1'b1;
                    default:    cnt_nxt_s  = up ? '0 : MAX;
                endcase
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Output/state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= '0;
            tc_r   <= 1'b0;
            ovf_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tc_r   <= tc_nxt_s;
            ovf_r  <= ovf_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    assign cnt  = cnt_r;
    assign tc   = tc_r;
    assign ovf  = ovf_r;
    assign done = done_r;

endmodule
